// File: rtl/vcve2_pkg.sv
// ---------------------------------------------------------------------------
// vcve2_pkg
// Shared types for the vcve2 core slice.
//   sleep_state_e      : state encoding of the sleep/wake controller
//   state_clock_en()   : clock-enable decode of a sleep controller state
//   state_core_sleep() : core-sleep indication decode of a state
// ---------------------------------------------------------------------------
package vcve2_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SLEEP = 3'd3,
        ST_WAKE  = 3'd4
    } sleep_state_e;

    // The core clock runs in every state except before boot and while asleep.
    function automatic logic state_clock_en(input sleep_state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_WAKE);
    endfunction

    function automatic logic state_core_sleep(input sleep_state_e s);
        return (s == ST_SLEEP);
    endfunction

endpackage

// File: rtl/vcve2_sleep_ctrl.sv
// ---------------------------------------------------------------------------
// vcve2_sleep_ctrl
// Core sleep/wake controller. Sequences boot, WFI-driven sleep (after the
// outstanding fetch/load-store/vector traffic drains), and wake-up with a
// programmable settle delay. Its clock_en_o drives en_i of the neighbouring
// vcve2_clock_gate; this block itself runs on the free-running clock.
//
// Parameters
//   WakeDelay : cycles the clock stays enabled in WAKE before RUN (>= 1)
//   CntWidth  : width of the saturating sleep-cycle counter
//
// Ports
//   clk_i          in   free-running ungated core clock
//   rst_i          in   synchronous active-high reset
//   fetch_enable_i in   boot permission from the SoC
//   wfi_req_i      in   one-cycle pulse, core retired WFI
//   irq_pending_i  in   enabled interrupt pending (level)
//   debug_req_i    in   external debug request (level)
//   instr_busy_i   in   instruction fetch outstanding
//   lsu_busy_i     in   data transaction outstanding
//   vec_busy_i     in   vector unit has in-flight operations
//   clock_en_o     out  registered core clock enable
//   core_sleep_o   out  high while the core clock is gated after WFI
//   wake_ack_o     out  one-cycle pulse when the core resumes (WAKE -> RUN)
//   sleep_cycles_o out  saturating count of cycles spent in SLEEP
// ---------------------------------------------------------------------------
module vcve2_sleep_ctrl
    import vcve2_pkg::*;
#(
    parameter int WakeDelay = 2,
    parameter int CntWidth  = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                fetch_enable_i,
    input  logic                wfi_req_i,
    input  logic                irq_pending_i,
    input  logic                debug_req_i,
    input  logic                instr_busy_i,
    input  logic                lsu_busy_i,
    input  logic                vec_busy_i,
    output logic                clock_en_o,
    output logic                core_sleep_o,
    output logic                wake_ack_o,
    output logic [CntWidth-1:0] sleep_cycles_o
);

    if (WakeDelay < 1) begin : gen_bad_wake_delay
        $error("vcve2_sleep_ctrl: WakeDelay must be at least 1");
    end

    // Wake counter only has to hold WakeDelay-1.
    localparam int WcW = (WakeDelay > 1) ? $clog2(WakeDelay) : 1;
    localparam logic [WcW-1:0] WakeLoad = WcW'(WakeDelay - 1);

    sleep_state_e        state_q;
    sleep_state_e        state_d;
    logic [WcW-1:0]      wake_cnt_q;
    logic [CntWidth-1:0] sleep_cnt_q;
    logic                clock_en_q;
    logic                core_sleep_q;
    logic                wake_ack_q;

    logic wake_event;
    logic idle;

    assign wake_event = irq_pending_i | debug_req_i;
    assign idle       = ~instr_busy_i & ~lsu_busy_i & ~vec_busy_i;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: begin
                if (fetch_enable_i) state_d = ST_WAKE;
            end
            ST_RUN: begin
                // A WFI that coincides with a wake event is a NOP.
                if (wfi_req_i && !wake_event) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A wake event aborts the drain even if the core is already idle.
                if (wake_event) state_d = ST_RUN;
                else if (idle)  state_d = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (wake_event) state_d = ST_WAKE;
            end
            ST_WAKE: begin
                if (wake_cnt_q == '0) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and registered outputs. The enables are decoded from the
    // next state so they switch on the same edge as the state register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_BOOT;
            clock_en_q   <= 1'b0;
            core_sleep_q <= 1'b0;
            wake_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clock_en_q   <= state_clock_en(state_d);
            core_sleep_q <= state_core_sleep(state_d);
            wake_ack_q   <= (state_q == ST_WAKE) && (state_d == ST_RUN);
        end
    end

    // -----------------------------------------------------------------------
    // Wake settle counter: loaded on entry to WAKE, counts down to zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wake_cnt_q <= '0;
        end else if ((state_q != ST_WAKE) && (state_d == ST_WAKE)) begin
            wake_cnt_q <= WakeLoad;
        end else if ((state_q == ST_WAKE) && (wake_cnt_q != '0)) begin
            wake_cnt_q <= wake_cnt_q - WcW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Sleep cycle counter: saturates at all-ones, cleared only by reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sleep_cnt_q <= '0;
        end else if ((state_q == ST_SLEEP) && (sleep_cnt_q != '1)) begin
            sleep_cnt_q <= sleep_cnt_q + CntWidth'(1);
        end
    end

    assign clock_en_o     = clock_en_q;
    assign core_sleep_o   = core_sleep_q;
    assign wake_ack_o     = wake_ack_q;
    assign sleep_cycles_o = sleep_cnt_q;

endmodule

// File: tb/tb_vcve2_sleep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vcve2_sleep_ctrl
// Directed bench for the sleep/wake controller. Two instances share all
// inputs: one with a 32-bit sleep counter, one with a 4-bit counter so that
// saturation is visible. Each step drives inputs, queues the outputs
// expected after the next clock edge and compares them one time unit later.
// ---------------------------------------------------------------------------
module tb_vcve2_sleep_ctrl;

    logic clk = 1'b0;
    logic rst, fetch_enable, wfi_req, irq_pending, debug_req;
    logic instr_busy, lsu_busy, vec_busy;

    logic        ce_a, cs_a, ack_a;
    logic [31:0] cnt_a;
    logic        ce_b, cs_b, ack_b;
    logic [3:0]  cnt_b;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    typedef struct {
        int          step;
        logic        ce;
        logic        cs;
        logic        ack;
        logic [31:0] cnt_a;
        logic [3:0]  cnt_b;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    vcve2_sleep_ctrl #(.WakeDelay(2), .CntWidth(32)) dut_a (
        .clk_i          (clk),
        .rst_i          (rst),
        .fetch_enable_i (fetch_enable),
        .wfi_req_i      (wfi_req),
        .irq_pending_i  (irq_pending),
        .debug_req_i    (debug_req),
        .instr_busy_i   (instr_busy),
        .lsu_busy_i     (lsu_busy),
        .vec_busy_i     (vec_busy),
        .clock_en_o     (ce_a),
        .core_sleep_o   (cs_a),
        .wake_ack_o     (ack_a),
        .sleep_cycles_o (cnt_a)
    );

    vcve2_sleep_ctrl #(.WakeDelay(2), .CntWidth(4)) dut_b (
        .clk_i          (clk),
        .rst_i          (rst),
        .fetch_enable_i (fetch_enable),
        .wfi_req_i      (wfi_req),
        .irq_pending_i  (irq_pending),
        .debug_req_i    (debug_req),
        .instr_busy_i   (instr_busy),
        .lsu_busy_i     (lsu_busy),
        .vec_busy_i     (vec_busy),
        .clock_en_o     (ce_b),
        .core_sleep_o   (cs_b),
        .wake_ack_o     (ack_b),
        .sleep_cycles_o (cnt_b)
    );

    task automatic chk1(input string tag, input int step, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%b expected=%b", tag, step, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int step, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step, obs, exp);
        end
    endtask

    // One clock: drive inputs, queue expectation, compare after the edge.
    task automatic cyc(input logic r, input logic fe, input logic wfi, input logic irq,
                       input logic dbg, input logic ib, input logic lb, input logic vb,
                       input logic e_ce, input logic e_cs, input logic e_ack,
                       input int e_cnt);
        exp_t e;
        exp_t got;
        rst          = r;
        fetch_enable = fe;
        wfi_req      = wfi;
        irq_pending  = irq;
        debug_req    = dbg;
        instr_busy   = ib;
        lsu_busy     = lb;
        vec_busy     = vb;
        step_no++;
        e.step  = step_no;
        e.ce    = e_ce;
        e.cs    = e_cs;
        e.ack   = e_ack;
        e.cnt_a = e_cnt;
        e.cnt_b = (e_cnt > 15) ? 4'd15 : e_cnt[3:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk1("clock_en",     got.step, ce_a,  got.ce);
        chk1("core_sleep",   got.step, cs_a,  got.cs);
        chk1("wake_ack",     got.step, ack_a, got.ack);
        chkn("sleep_cycles", got.step, cnt_a, got.cnt_a);
        chkn("sleep_cycles_w4", got.step, {28'd0, cnt_b}, {28'd0, got.cnt_b});
        chk1("clock_en_w4",  got.step, ce_b,  got.ce);
    endtask

    // Quiet cycle: no requests, nothing busy.
    task automatic quiet(input logic e_ce, input logic e_cs, input logic e_ack, input int e_cnt);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, e_ce, e_cs, e_ack, e_cnt);
    endtask

    initial begin
        // Reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Boot: held off by fetch_enable, then two WAKE cycles and an ack
        for (int i = 0; i < 5; i++) quiet(0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        quiet(1, 0, 0, 0);
        quiet(1, 0, 1, 0);
        quiet(1, 0, 0, 0);

        // Sleep / wake with nothing busy
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);   // -> DRAIN
        quiet(0, 1, 0, 0);                          // -> SLEEP
        for (int k = 1; k <= 10; k++) quiet(0, 1, 0, k);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 11);  // wake event -> WAKE
        quiet(1, 0, 0, 11);
        quiet(1, 0, 1, 11);                         // ack 3 cycles after the event
        quiet(1, 0, 0, 11);

        // Drain held by lsu_busy for 4 cycles
        cyc(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 11);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 11);
        quiet(0, 1, 0, 11);                         // SLEEP after busy drops
        // In SLEEP, fetch_enable / busy / wfi are ignored
        cyc(0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 0, 12);
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 13);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 14);  // debug wakes
        quiet(1, 0, 0, 14);
        quiet(1, 0, 1, 14);
        quiet(1, 0, 0, 14);

        // WFI colliding with a wake event is a NOP
        cyc(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 14);
        quiet(1, 0, 0, 14);                         // still RUN, no sleep
        // Debug during DRAIN returns to RUN without an ack
        cyc(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 14);  // -> DRAIN (vec busy)
        cyc(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 14);  // -> RUN
        quiet(1, 0, 0, 14);
        // Wake event beats idle in DRAIN
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 14);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 14);
        quiet(1, 0, 0, 14);

        // Long sleep: 4-bit counter saturates at 15
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 14);
        quiet(0, 1, 0, 14);
        for (int k = 1; k <= 20; k++) quiet(0, 1, 0, 14 + k);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 35);  // -> WAKE
        // Reset mid-WAKE
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet(0, 0, 0, 0);                          // BOOT, no late ack
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        quiet(1, 0, 0, 0);
        quiet(1, 0, 1, 0);
        // Reset mid-DRAIN
        cyc(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        quiet(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vcve2_sleep_ctrl.md
VCVE2_SLEEP_CTRL -- requirements
Module: vcve2_sleep_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WakeDelay, 2, cycles clock stays enabled in WAKE before RUN resumes; elaboration error if < 1.
- CntWidth, 32, width of sleep cycle counter.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i  in  1  free-running ungated core clock.
- rst_i  in  1  synchronous active-high reset.
- fetch_enable_i  in  1  boot permission from SoC.
- wfi_req_i  in  1  one-cycle pulse, core retired WFI.
- irq_pending_i  in  1  any enabled interrupt pending (level).
- debug_req_i  in  1  external debug request (level).
- instr_busy_i  in  1  instruction fetch transaction outstanding.
- lsu_busy_i  in  1  data transaction outstanding.
- vec_busy_i  in  1  vector unit has in-flight operations.
- clock_en_o  out  1  registered enable, drives en_i of vcve2_clock_gate.
- core_sleep_o  out  1  high while core clock is gated after WFI.
- wake_ack_o  out  1  one-cycle pulse when core resumes after sleep.
- sleep_cycles_o  out  CntWidth  saturating count of cycles spent in SLEEP.

REQ-003 The block SHALL have one clock, clk_i; the reset is synchronous and active-high on rst_i.

Function
REQ-004 Wake event SHALL be defined as irq_pending_i | debug_req_i.
REQ-005 Idle SHALL be defined as !instr_busy_i & !lsu_busy_i & !vec_busy_i.
REQ-006 The FSM SHALL have states BOOT, RUN, DRAIN, SLEEP, WAKE.
REQ-007 BOOT: clock_en_o=0; fetch_enable_i=1 -> WAKE.
REQ-008 RUN: clock_en_o=1; wfi_req_i=1 with no wake event -> DRAIN; wfi_req_i=1 with a simultaneous wake event SHALL stay in RUN, so WFI acts as a NOP.
REQ-009 DRAIN: clock_en_o=1; a wake event -> RUN with no wake_ack_o; otherwise Idle -> SLEEP; otherwise stay in DRAIN. The wake event has priority over Idle.
REQ-010 SLEEP: clock_en_o=0, core_sleep_o=1; a wake event -> WAKE. fetch_enable_i and busy inputs SHALL be ignored.
REQ-011 WAKE: clock_en_o=1, core_sleep_o=0; a down-counter loaded with WakeDelay-1 on entry decrements each cycle; at 0 -> RUN. The wake event need not persist through WAKE.
REQ-012 wake_ack_o SHALL be 1 for exactly the single cycle in which WAKE -> RUN is taken, including the first wake from BOOT.
REQ-013 clock_en_o and core_sleep_o SHALL be flop outputs equal to the decode of the next state, so they change together with the state register.
REQ-014 sleep_cycles_o SHALL increment by 1 each cycle the state register is SLEEP, hold at 2^CntWidth-1 on saturation, and clear only on reset.
REQ-015 wfi_req_i asserted in any state other than RUN SHALL be ignored.
REQ-016 Wake latency: from a cycle with a wake event in SLEEP to wake_ack_o SHALL be exactly WakeDelay+1 cycles.

Reset
REQ-017 While rst_i=1 at a clk_i edge: state=BOOT, clock_en_o=0, core_sleep_o=0, wake_ack_o=0, sleep_cycles_o=0, wake counter=0.
REQ-018 Reset asserted in any state, including mid-DRAIN or mid-WAKE, SHALL take effect at the next edge with no other side effects.

Structure
REQ-019 The state enum sleep_state_e SHALL live in vcve2_pkg; WakeDelay and CntWidth stay module parameters.
REQ-020 The block SHALL be flat, with no sub-modules; it is instantiated beside vcve2_clock_gate, with clock_en_o driving its en_i.

Verification
REQ-021 Boot: rst_i 1->0, fetch_enable_i=0 for 5 cycles -> clock_en_o=0; fetch_enable_i=1 -> WAKE for 2 cycles, wake_ack_o pulse, RUN with clock_en_o=1.
REQ-022 Sleep/wake: in RUN, pulse wfi_req_i with all busy=0 -> DRAIN 1 cycle, SLEEP; hold 10 cycles -> sleep_cycles_o=10; irq_pending_i=1 -> wake_ack_o exactly 3 cycles later (WakeDelay=2).
REQ-023 Drain: wfi_req_i with lsu_busy_i=1 for 4 cycles -> clock_en_o stays 1 in DRAIN, SLEEP entered the cycle after lsu_busy_i drops.
REQ-024 Collisions: wfi_req_i with irq_pending_i=1 -> state stays RUN; debug_req_i=1 during DRAIN -> RUN, wake_ack_o=0, sleep_cycles_o unchanged.
REQ-025 Saturation and reset: CntWidth=4, sleep 20 cycles -> sleep_cycles_o=15; assert rst_i mid-WAKE -> BOOT, all outputs 0 next cycle.
